dmem_ls: RTL and testbench
==========================

Name: dmem_ls

Overview:
- Parametrised data memory for the core's load/store path.
- Single-port synchronous RAM of DEPTH_WORDS x 32 bits.
- Valid/ready request and response channels, so it can sit behind an arbiter or a stalling pipeline.
- Performs RISC-V sub-word formatting internally: LB/LH/LW/LBU/LHU and SB/SH/SW lane steering.
- Reports misaligned or out-of-range accesses as an error response and never corrupts memory on such an access.

Parameters:
- DEPTH_WORDS, 16384, number of 32-bit words; power of two, at least 4.
- ADDR_W, 16, request byte-address width; must be at least log2(DEPTH_WORDS)+2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous assert, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads only: zero-extend if 1, sign-extend if 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  formatted load data; 0 for stores and errors.
- resp_err  out  1  access was misaligned, illegal size or out of range.
- resp_write  out  1  response belongs to a store.

Behaviour:
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, resp_write=0, req_ready=0 while rst is high. RAM contents are not reset.
- Reset mid-operation: a held response is dropped. No write occurs in any cycle where rst is high.
- req_ready = !rst && (!resp_valid || resp_ready). At most one outstanding request; the response register is the only buffer.
- Accept: req_valid && req_ready at a rising edge.
- Latency: response is valid on the edge following acceptance. Throughput is 1 per cycle while resp_ready=1.
- Word index = req_addr[ADDR_W-1:2]; offset = req_addr[1:0].
- Error conditions, any of:
  - req_size==3;
  - size half with offset[0]=1;
  - size word with offset!=0;
  - word index >= DEPTH_WORDS (only possible when ADDR_W > log2(DEPTH_WORDS)+2).
- On error: no RAM write; response has resp_err=1, resp_rdata=0, resp_write=req_we.
- Store lane enables:
  - byte: 1<<offset;
  - half: 4'b0011<<offset;
  - word: 4'b1111.
- Store data: wdata byte replicated across all four lanes for byte stores, half replicated across both halves for half stores. Only enabled lanes are written, at the acceptance edge.
- Store response: resp_write=1, resp_rdata=0, resp_err=0.
- Load path:
  - RAM read is synchronous at the acceptance edge.
  - offset, size and unsigned are captured into a 4-bit side register at the same edge.
  - Formatting (lane select plus sign/zero extension) is combinational from the RAM output and side register.
  - The formatted result is latched into the resp_rdata hold register when the response is first presented, so it stays stable while resp_ready=0, independent of later RAM activity.
- Response hold: while resp_valid && !resp_ready, all resp_* outputs are stable and req_ready=0.
- Same-cycle completion and new accept: when resp_ready=1 and a new request is accepted in the same cycle, the old response retires and the new one appears on the next edge with no bubble.
- Store followed by load to the same word: the load, accepted one cycle after the store, returns the updated data (write-first ordering by edge).
- Implementation constraint: RAM must infer block RAM. Use one read port, byte-write-enable per lane, and no asynchronous read.

Test Plan:
- Word store/load: SW 0xDEADBEEF @0x0100, then LW @0x0100 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_write=0, one cycle after each accept.
- Sub-word load extension: after the above, LB @0x0103 -> 0xFFFFFFDE; LBU @0x0103 -> 0x000000DE; LH @0x0102 -> 0xFFFFDEAD; LHU @0x0100 -> 0x0000BEEF.
- Sub-word stores: SB 0x55 @0x0101, then LW @0x0100 -> 0xDEAD55EF; SH 0x1234 @0x0102, then LW -> 0x123455EF.
- Errors: LW @0x0102, SH @0x0101, size=3 -> resp_err=1, resp_rdata=0. A following LW @0x0100 -> 0x123455EF (memory unchanged). With ADDR_W=17 and DEPTH_WORDS=16384, LW @0x10000 -> resp_err=1.
- Backpressure: issue LW with resp_ready=0 for 5 cycles while req_valid stays high with a store to the same word -> req_ready=0, resp_rdata stable, no write. On release, old data retires, then the store is accepted the next edge.
- Back-to-back and reset: 8 consecutive loads with resp_ready=1 -> 8 responses on 8 consecutive cycles in order. Assert rst while a response is held -> resp_valid=0 immediately. After release, memory still holds the earlier writes.

Source files
------------

// File: rtl/dmem_ls.sv
// Single-port byte-enabled data memory with valid/ready load/store channels.
// Sub-word lane steering and sign/zero extension follow RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW.
module dmem_ls #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_write
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned IW = ADDR_W - 2;

    logic [1:0]    off;
    logic [IW-1:0] widx;
    logic [AW-1:0] ram_addr;
    logic          oob;
    logic          err_c;
    logic          accept;
    logic          do_write;
    logic          do_read;
    logic [3:0]    be;
    logic [31:0]   wrep;
    logic [3:0]    side_c;
    logic [3:0]    side_q;
    logic [31:0]   ram_q;
    logic [31:0]   fmt;
    logic [31:0]   hold_q;
    logic          fresh_q;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;

    assign off      = req_addr[1:0];
    assign widx     = req_addr[ADDR_W-1:2];
    assign ram_addr = req_addr[AW+1:2];

    // Out-of-range only exists when the address has bits above the RAM index.
    generate
        if (IW > AW) begin : g_oob
            assign oob = |widx[IW-1:AW];
        end else begin : g_no_oob
            assign oob = 1'b0;
        end
    endgenerate

    assign err_c = (req_size == 2'd3)
                 | ((req_size == 2'd1) & off[0])
                 | ((req_size == 2'd2) & (off != 2'd0))
                 | oob;

    assign req_ready = !rst && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;
    assign do_write  = accept && req_we && !err_c;
    assign do_read   = accept && !req_we && !err_c;

    // Lane enables and replicated store data.
    always_comb begin
        be   = 4'b0000;
        wrep = req_wdata;
        case (req_size)
            2'd0: begin
                be   = 4'(4'b0001 << off);
                wrep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be   = 4'(4'b0011 << off);
                wrep = {2{req_wdata[15:0]}};
            end
            2'd2: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_addr][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
        if (do_read) ram_q <= mem[ram_addr];
    end

    // Side encoding: [3]=unsigned, [2]=byte, [1:0]=offset; a word load sets [0]
    // (a legal half never has an odd offset, so {byte=0,[0]=1} means word).
    assign side_c = {req_unsigned, req_size == 2'd0, off[1], off[0] | (req_size == 2'd2)};

    always_comb begin
        fmt    = ram_q;
        lane_b = ram_q[{side_q[1:0], 3'b000} +: 8];
        lane_h = side_q[1] ? ram_q[31:16] : ram_q[15:0];
        if (side_q[2]) begin
            fmt = side_q[3] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
        end else if (!side_q[0]) begin
            fmt = side_q[3] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
        end
    end

    // Response register; load data is frozen into hold_q after its first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_write <= 1'b0;
            fresh_q    <= 1'b0;
            hold_q     <= 32'd0;
            side_q     <= 4'd0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= err_c;
            resp_write <= req_we;
            fresh_q    <= do_read;
            hold_q     <= 32'd0;
            side_q     <= side_c;
        end else begin
            if (resp_ready) resp_valid <= 1'b0;
            if (fresh_q) begin
                hold_q  <= fmt;
                fresh_q <= 1'b0;
            end
        end
    end

    assign resp_rdata = fresh_q ? fmt : hold_q;

endmodule

// File: tb/tb_dmem_ls.sv
// Randomized scoreboard bench for dmem_ls against a byte-array memory model.
module tb_dmem_ls;

    localparam int unsigned DEPTH = 16384;
    localparam int unsigned AW    = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          resp_write;

    dmem_ls #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_write(resp_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mref [DEPTH*4];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rr_mode = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: byte-addressed memory, applied in acceptance order.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [AW-1:0] addr, input logic [31:0] wdata);
        exp_t e;
        int a, nb;
        logic [31:0] v;
        a = int'(addr);
        e.wr = we;
        e.rdata = 32'd0;
        e.acc = 0;
        e.err = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) ||
                (size == 2'd2 && a % 4 != 0) || (a >= int'(DEPTH) * 4);
        if (!e.err) begin
            nb = 1 << size;
            if (we) begin
                for (int k = 0; k < nb; k++) mref[a+k] = wdata[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v = v | (32'(mref[a+k]) << (8*k));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                e.rdata = v;
            end
        end
        return e;
    endfunction

    task automatic set_rr(input int mode);
        rr_mode = mode;
        resp_ready = (mode != 2);
    endtask

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0: resp_ready = 1'b1;
            1: resp_ready = ($urandom_range(0, 3) != 0);
            default: resp_ready = 1'b0;
        endcase
    end

    // Drive one request and hold it until accepted; returns at posedge+1.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wdata);
        exp_t e;
        int n;
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout: req_ready stuck low for addr %h", addr);
                req_valid = 1'b0;
                return;
            end
        end
        e = model(we, size, uns, addr, wdata);
        e.acc = cyc;
        sbq.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Monitor: handshake rule, latency, hold stability and scoreboard compare.
    logic        held = 1'b0;
    logic [31:0] p_rd;
    logic        p_err, p_wr;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_resp_rdata", resp_rdata, 32'd0);
            check("rst_err_write", {30'd0, resp_err, resp_write}, 32'd0);
            held = 1'b0;
        end else begin
            check("req_ready_rule", 32'(req_ready), 32'(!(resp_valid && !resp_ready)));
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: rdata %h with empty scoreboard", resp_rdata);
                end else begin
                    if (!held) check("latency", 32'(cyc), 32'(sbq[0].acc + 1));
                    else begin
                        check("hold_rdata", resp_rdata, p_rd);
                        check("hold_flags", {30'd0, resp_err, resp_write}, {30'd0, p_err, p_wr});
                    end
                    if (resp_ready) begin
                        e = sbq.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_err", 32'(resp_err), 32'(e.err));
                        check("resp_write", 32'(resp_write), 32'(e.wr));
                    end
                end
            end
            held = resp_valid && !resp_ready;
            p_rd = resp_rdata; p_err = resp_err; p_wr = resp_write;
        end
    end

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int start;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        set_rr(0);

        // Word, sub-word and error cases.
        issue(1'b1, 2'd2, 1'b0, 17'h00100, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0);
        issue(1'b0, 2'd0, 1'b0, 17'h00103, 32'd0);
        issue(1'b0, 2'd0, 1'b1, 17'h00103, 32'd0);
        issue(1'b0, 2'd1, 1'b0, 17'h00102, 32'd0);
        issue(1'b0, 2'd1, 1'b1, 17'h00100, 32'd0);
        issue(1'b1, 2'd0, 1'b0, 17'h00101, 32'h00000055);
        issue(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0);
        issue(1'b1, 2'd1, 1'b0, 17'h00102, 32'h00001234);
        issue(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 17'h00102, 32'd0);
        issue(1'b1, 2'd1, 1'b0, 17'h00101, 32'hFFFFFFFF);
        issue(1'b0, 2'd3, 1'b0, 17'h00100, 32'd0);
        issue(1'b1, 2'd3, 1'b0, 17'h00104, 32'hFFFFFFFF);
        issue(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 17'h10000, 32'd0);
        issue(1'b1, 2'd2, 1'b0, 17'h10000, 32'h11111111);
        drain();
        check("plan_word_value", {mref[32'h103], mref[32'h102], mref[32'h101], mref[32'h100]},
              32'h123455EF);

        // Backpressure: held load, store to the same word waits behind it.
        set_rr(2);
        @(posedge clk); #1;
        issue(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0);
        fork
            issue(1'b1, 2'd2, 1'b0, 17'h00100, 32'hCAFEF00D);
            begin
                repeat (5) @(posedge clk);
                #2 set_rr(0);
            end
        join
        issue(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0);
        drain();

        // Fill a region, then randomized traffic with random backpressure.
        for (int w = 0; w < 32; w++)
            issue(1'b1, 2'd2, 1'b0, 17'(32'h100 + 4*w), $urandom);
        set_rr(1);
        for (int t = 0; t < 300; t++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 15) == 0) a = 17'(32'h10000 + $urandom_range(0, 32'hFFFF));
            else a = 17'(32'h100 + $urandom_range(0, 127));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        set_rr(0);
        drain();

        // Eight back-to-back loads, one per cycle.
        start = cyc;
        for (int i = 0; i < 8; i++) issue(1'b0, 2'd2, 1'b0, 17'(32'h140 + 4*i), 32'd0);
        check("b2b_cycles", 32'(cyc - start), 32'd8);
        drain();

        // Reset while a response is held.
        set_rr(2);
        @(posedge clk); #1;
        issue(1'b0, 2'd2, 1'b0, 17'h00104, 32'd0);
        check("held_before_rst", 32'(resp_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_drops_valid", 32'(resp_valid), 32'd0);
        check("rst_drops_rdata", resp_rdata, 32'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_rr(0);
        for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 1'b0, 17'(32'h100 + 4*i), 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
